// File: rtl/conn_setup_tx_pkg.sv
// Shared NIC definitions for the connection-setup path.
// Holds the request descriptor, the setup frame and status formats, the
// setUp* command encodings and the state type of the setup transmitter.
package conn_setup_tx_pkg;

    localparam int unsigned CONN_SETUP_DATA_W = 32;
    localparam int unsigned CONN_SETUP_CMD_W  = 4;

    // setUp* command encodings carried in ConnSetupFrame.cmd
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpNone                  = 4'd0;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpConnId                = 4'd1;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpOpen                  = 4'd2;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpDestIPv4              = 4'd3;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpDestPort              = 4'd4;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpClientFlowId          = 4'd5;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpRemoteQueuePairNumber = 4'd6;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpPKey                  = 4'd7;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpQKey                  = 4'd8;
    localparam logic [CONN_SETUP_CMD_W-1:0] SetUpEnable                = 4'd9;

    typedef struct packed {
        logic [CONN_SETUP_CMD_W-1:0]  cmd;
        logic [CONN_SETUP_DATA_W-1:0] data;
    } ConnSetupFrame;

    typedef struct packed {
        logic valid;
        logic error;
    } ConnSetupStatus;

    typedef struct packed {
        logic [15:0] conn_id;
        logic        open;
        logic [31:0] dest_ip;
        logic [15:0] dest_port;
        logic [15:0] client_flow_id;
        logic [23:0] remote_qp_num;
        logic [15:0] p_key;
        logic [31:0] q_key;
    } ConnDesc;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StGap,
        StWaitStatus,
        StDone
    } conn_setup_state_e;

endpackage

// File: rtl/conn_setup_tx.sv
// Connection setup transmitter.
// Accepts one connection descriptor at a time and serialises it into a
// sequence of setUp* frames toward the connection-manager parser, then waits
// for the manager's status (or a timeout) and emits a one-cycle completion.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake, req_desc holds a ConnDesc
//   conn_setup_en_out          frame strobe (registered)
//   conn_setup_frame_out       ConnSetupFrame, all zeros when strobe is low
//   conn_setup_status_in       ConnSetupStatus from the manager
//   done_valid / done_error    completion pulse and its error qualifier
//   busy                       a request is in flight
module conn_setup_tx
    import conn_setup_tx_pkg::*;
#(
    parameter int unsigned NIC_ID         = 0,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [$bits(ConnDesc)-1:0]          req_desc,
    output logic                                conn_setup_en_out,
    output logic [$bits(ConnSetupFrame)-1:0]    conn_setup_frame_out,
    input  logic [$bits(ConnSetupStatus)-1:0]   conn_setup_status_in,
    output logic                                done_valid,
    output logic                                done_error,
    output logic                                busy
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    // NIC_ID only labels instances in simulation logs; nothing in hardware uses it.
    logic unused_nic_id;
    assign unused_nic_id = ^NIC_ID;

    ConnDesc        desc_in;
    ConnSetupStatus status_in;
    assign desc_in   = ConnDesc'(req_desc);
    assign status_in = ConnSetupStatus'(conn_setup_status_in);

    conn_setup_state_e state_q;
    ConnDesc           desc_q;
    logic [3:0]        idx_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic [TmoW-1:0]   tmo_cnt_q;
    logic              en_q;
    ConnSetupFrame     frame_q;
    logic              done_valid_q;
    logic              done_error_q;
    logic              tmo_hit;

    // Frame for position idx of the sequence selected by d.open.
    function automatic ConnSetupFrame make_frame(input ConnDesc d, input logic [3:0] idx);
        ConnSetupFrame f;
        f = '0;
        case (d.open)
            1'b1: begin
                case (idx)
                    4'd0: begin f.cmd = SetUpConnId;       f.data = 32'(d.conn_id);        end
                    4'd1: begin f.cmd = SetUpOpen;         f.data = 32'(d.open);           end
                    4'd2: begin f.cmd = SetUpDestIPv4;     f.data = 32'(d.dest_ip);        end
                    4'd3: begin f.cmd = SetUpDestPort;     f.data = 32'(d.dest_port);      end
                    4'd4: begin f.cmd = SetUpClientFlowId; f.data = 32'(d.client_flow_id); end
                    4'd5: begin
                        f.cmd  = SetUpRemoteQueuePairNumber;
                        f.data = 32'(d.remote_qp_num);
                    end
                    4'd6: begin f.cmd = SetUpPKey;         f.data = 32'(d.p_key);          end
                    4'd7: begin f.cmd = SetUpQKey;         f.data = 32'(d.q_key);          end
                    4'd8: begin f.cmd = SetUpEnable;       f.data = '0;                    end
                    default: f = '0;
                endcase
            end
            default: begin
                case (idx)
                    4'd0: begin f.cmd = SetUpConnId; f.data = 32'(d.conn_id); end
                    4'd1: begin f.cmd = SetUpOpen;   f.data = 32'(d.open);    end
                    4'd2: begin f.cmd = SetUpEnable; f.data = '0;             end
                    default: f = '0;
                endcase
            end
        endcase
        return f;
    endfunction

    function automatic logic is_last(input logic open, input logic [3:0] idx);
        return open ? (idx == 4'd8) : (idx == 4'd2);
    endfunction

    // The cycle that would take the counter to TIMEOUT_CYCLES ends the wait.
    assign tmo_hit = (32'(tmo_cnt_q) + 32'd1) >= TIMEOUT_CYCLES;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            desc_q       <= '0;
            idx_q        <= '0;
            gap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            en_q         <= 1'b0;
            frame_q      <= '0;
            done_valid_q <= 1'b0;
            done_error_q <= 1'b0;
        end else begin
            // Strobe and completion are single-cycle; frame is zero when idle.
            en_q         <= 1'b0;
            frame_q      <= '0;
            done_valid_q <= 1'b0;
            done_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        desc_q  <= desc_in;
                        idx_q   <= 4'd0;
                        state_q <= StSend;
                        en_q    <= 1'b1;
                        frame_q <= make_frame(desc_in, 4'd0);
                    end
                end
                StSend: begin
                    if (is_last(desc_q.open, idx_q)) begin
                        state_q   <= StWaitStatus;
                        tmo_cnt_q <= '0;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        if (GAP_CYCLES == 0) begin
                            en_q    <= 1'b1;
                            frame_q <= make_frame(desc_q, idx_q + 4'd1);
                        end else begin
                            state_q   <= StGap;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                StGap: begin
                    // idx_q already points at the next frame here.
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StSend;
                        en_q    <= 1'b1;
                        frame_q <= make_frame(desc_q, idx_q);
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                StWaitStatus: begin
                    if (tmo_cnt_q != TmoMax) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                    // A status arriving on the timeout cycle wins.
                    if (status_in.valid) begin
                        state_q      <= StDone;
                        done_valid_q <= 1'b1;
                        done_error_q <= status_in.error;
                    end else if (tmo_hit) begin
                        state_q      <= StDone;
                        done_valid_q <= 1'b1;
                        done_error_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready            = (state_q == StIdle) && !reset;
    assign busy                 = (state_q != StIdle);
    assign conn_setup_en_out    = en_q;
    assign conn_setup_frame_out = frame_q;
    assign done_valid           = done_valid_q;
    assign done_error           = done_error_q;

endmodule
